trap_sequencer: RTL and testbench

- Sequences every change of control flow through the Machine-mode CSR file: synchronous exceptions, the timer interrupt, and mret.
- Sits between the MEM/commit stage and the CSR file.
- Selects the winning event and waits for outstanding bus transactions to drain.
- Issues a single-cycle trap_enter or mret_exec pulse to the CSR file, then flushes the pipeline and holds a fetch redirect until the fetch unit accepts it.

---
 rtl/trap_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: routes every Machine-mode control-flow change (synchronous
// exception, timer interrupt, mret) through the CSR file.
// An event is picked at commit. The sequencer waits for the bus to drain,
// then pulses trap_enter_o or mret_exec_o for one cycle with a flush. After
// that it holds a fetch redirect until the fetch unit accepts it.
//
// Ports:
//   clk, rst (async, active-high)
//   exc_*_i / mret_req_i / commit_*_i   commit-stage events
//   timer_pending_i, mie_mtie_i,
//   mstatus_mie_i, priv_mode_i          interrupt enable and gating
//   mtvec_in_i, mepc_in_i               CSR file values
//   mem_busy_i                          outstanding bus transaction
//   redirect_ready_i                    fetch accepts the redirect
//   stall_o, flush_o                    pipeline control
//   trap_enter_o, trap_cause_o,
//   trap_pc_o, trap_val_o               trap-entry pulse and data to the CSR file
//   mret_exec_o                         mret pulse to the CSR file
//   redirect_valid_o, redirect_pc_o     fetch redirect
//   drain_timeout_o                     sticky flag, set when a drain gave up waiting
//
// Optional build macro: TRAP_VECTORED_EN enables vectored interrupt targets
// when mtvec mode is 2'b01.
module trap_sequencer #(
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_req_i,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_pc_i,
    input  logic        timer_pending_i,
    input  logic        mie_mtie_i,
    input  logic        mstatus_mie_i,
    input  logic [1:0]  priv_mode_i,
    input  logic [31:0] mtvec_in_i,
    input  logic [31:0] mepc_in_i,
    input  logic        mem_busy_i,
    input  logic        redirect_ready_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        trap_enter_o,
    output logic [31:0] trap_cause_o,
    output logic [31:0] trap_pc_o,
    output logic [31:0] trap_val_o,
    output logic        mret_exec_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        drain_timeout_o
);

    typedef enum logic [2:0] {
        StIdle, StDrain, StDrainR, StEnter, StMret, StRedirect
    } state_e;

    localparam logic [7:0] CntMax = 8'(DRAIN_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] target_q, target_d;
    logic        timeout_q, timeout_d;

    logic        irq_take;
    logic        drain_done;
    logic [31:0] trap_target;

    // Interrupts are globally enabled in U-mode regardless of mstatus.MIE.
    assign irq_take   = timer_pending_i & mie_mtie_i &
                        (mstatus_mie_i | (priv_mode_i != 2'd3)) & commit_valid_i;
    assign drain_done = ~mem_busy_i | (cnt_q == CntMax);

    always_comb begin
        trap_target = mtvec_in_i & ~32'h3;
`ifdef TRAP_VECTORED_EN
        // Vectored mode applies to interrupts only. The offset is 4 * cause[30:0],
        // truncated to 32 bits.
        if (mtvec_in_i[1:0] == 2'b01 && cause_q[31]) begin
            trap_target = (mtvec_in_i & ~32'h3) + {cause_q[29:0], 2'b00};
        end
`endif
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        cause_d          = cause_q;
        epc_d            = epc_q;
        tval_d           = tval_q;
        target_d         = target_q;
        timeout_d        = timeout_q;
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        trap_enter_o     = 1'b0;
        trap_cause_o     = 32'h0;
        trap_pc_o        = 32'h0;
        trap_val_o       = 32'h0;
        mret_exec_o      = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                // Lower-priority events in the same cycle are dropped.
                if (exc_valid_i) begin
                    cause_d = {28'b0, exc_code_i};
                    epc_d   = exc_pc_i;
                    tval_d  = exc_tval_i;
                    state_d = StDrain;
                end else if (mret_req_i) begin
                    state_d = StDrainR;
                end else if (irq_take) begin
                    cause_d = 32'h8000_0007;
                    epc_d   = commit_pc_i;
                    tval_d  = 32'h0;
                    state_d = StDrain;
                end
            end
            StDrain, StDrainR: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (drain_done) begin
                    cnt_d = 8'd0;
                    // Leaving while the bus is still busy means the wait timed out.
                    if (mem_busy_i) begin
                        timeout_d = 1'b1;
                    end
                    state_d = (state_q == StDrain) ? StEnter : StMret;
                end
            end
            StEnter: begin
                stall_o      = 1'b1;
                flush_o      = 1'b1;
                trap_enter_o = 1'b1;
                trap_cause_o = cause_q;
                trap_pc_o    = epc_q;
                trap_val_o   = tval_q;
                target_d     = trap_target;
                state_d      = StRedirect;
            end
            StMret: begin
                stall_o     = 1'b1;
                flush_o     = 1'b1;
                mret_exec_o = 1'b1;
                // mepc is only rewritten on trap entry, so this cycle's value is final.
                target_d    = mepc_in_i;
                state_d     = StRedirect;
            end
            StRedirect: begin
                stall_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q;
                if (redirect_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign drain_timeout_o = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            cause_q   <= 32'h0;
            epc_q     <= 32'h0;
            tval_q    <= 32'h0;
            target_q  <= 32'h0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            tval_q    <= tval_d;
            target_q  <= target_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer. A table of events is applied from the IDLE
// state. The expected CSR-file transaction for each event is queued when the
// event is driven, and is compared when the pulse appears. Hand-written
// sequences cover reset behaviour and the sticky timeout flag.
module tb_trap_sequencer;

    localparam int unsigned DrainTo = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, mret_req, commit_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc, exc_tval, commit_pc, mtvec_in, mepc_in;
    logic        timer_pending, mie_mtie, mstatus_mie;
    logic [1:0]  priv_mode;
    logic        mem_busy, redirect_ready;
    logic        stall, flush, trap_enter, mret_exec, redirect_valid, drain_timeout;
    logic [31:0] trap_cause, trap_pc, trap_val, redirect_pc;

    trap_sequencer #(.DRAIN_TIMEOUT(DrainTo)) dut (
        .clk              (clk),
        .rst              (rst),
        .exc_valid_i      (exc_valid),
        .exc_code_i       (exc_code),
        .exc_pc_i         (exc_pc),
        .exc_tval_i       (exc_tval),
        .mret_req_i       (mret_req),
        .commit_valid_i   (commit_valid),
        .commit_pc_i      (commit_pc),
        .timer_pending_i  (timer_pending),
        .mie_mtie_i       (mie_mtie),
        .mstatus_mie_i    (mstatus_mie),
        .priv_mode_i      (priv_mode),
        .mtvec_in_i       (mtvec_in),
        .mepc_in_i        (mepc_in),
        .mem_busy_i       (mem_busy),
        .redirect_ready_i (redirect_ready),
        .stall_o          (stall),
        .flush_o          (flush),
        .trap_enter_o     (trap_enter),
        .trap_cause_o     (trap_cause),
        .trap_pc_o        (trap_pc),
        .trap_val_o       (trap_val),
        .mret_exec_o      (mret_exec),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .drain_timeout_o  (drain_timeout)
    );

    always #5 clk = ~clk;

    // kind: 0 = no event, 1 = trap, 2 = mret
    typedef struct {
        logic        ev;
        logic [3:0]  code;
        logic [31:0] epc, tval;
        logic        mret, cv;
        logic [31:0] cpc;
        logic        tp, mtie, smie;
        logic [1:0]  priv;
        logic [31:0] mtvec, mepc;
        int          busy, rdly;
        int          kind;
        logic [31:0] cause, pc, val, target;
        int          drain;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] cause, pc, val, target;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        exc_valid     = 1'b0;
        mret_req      = 1'b0;
        commit_valid  = 1'b0;
        timer_pending = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   cyc, rem, drain_n, rv_n, pulse_cyc;
        bit   done;
        exp_t e;
        string p;
        p = $sformatf("v%0d", id);
        e = '{default: 0};
        drain_n = 0; rv_n = 0; pulse_cyc = -1; done = 0;
        exc_valid = v.ev;   exc_code = v.code;   exc_pc = v.epc;   exc_tval = v.tval;
        mret_req = v.mret;  commit_valid = v.cv; commit_pc = v.cpc;
        timer_pending = v.tp; mie_mtie = v.mtie; mstatus_mie = v.smie; priv_mode = v.priv;
        mtvec_in = v.mtvec; mepc_in = v.mepc;
        mem_busy = (v.busy > 0);
        redirect_ready = 1'b0;
        rem = v.busy - 1;
        if (v.kind != 0) sb.push_back('{v.kind, v.cause, v.pc, v.val, v.target});
        tick();
        cyc = 1;
        clear_events();
        while (!done && cyc < 400) begin
            if (v.kind == 0 && cyc == 1) chk({p, "_stall_idle"}, stall, 0);
            if (stall && !trap_enter && !mret_exec && !redirect_valid) drain_n++;
            if (trap_enter || mret_exec) begin
                pulse_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s_unexpected_pulse actual=%0b%0b required=00",
                             p, trap_enter, mret_exec);
                end else begin
                    e = sb.pop_front();
                    chk({p, "_flush"}, flush, 1);
                    chk({p, "_kind"}, {30'b0, mret_exec, trap_enter}, e.kind);
                    if (e.kind == 1) begin
                        chk({p, "_cause"}, trap_cause, e.cause);
                        chk({p, "_pc"}, trap_pc, e.pc);
                        chk({p, "_val"}, trap_val, e.val);
                    end
                end
            end else if (v.kind != 0 && cyc == 1) begin
                chk({p, "_cause_outside_enter"}, trap_cause, 0);
            end
            if (redirect_valid) begin
                rv_n++;
                chk({p, "_redirect_pc"}, redirect_pc, e.target);
            end
            if (v.kind == 0 && cyc >= 6) done = 1;
            if (v.kind != 0 && rv_n > 0 && !stall) done = 1;
            mem_busy = (rem > 0);
            if (rem > 0) rem--;
            redirect_ready = redirect_valid && (rv_n > v.rdly);
            if (!done) begin
                tick();
                cyc++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=running required=idle", p);
        end
        if (v.kind != 0) begin
            chk({p, "_drain_cycles"}, drain_n, v.drain);
            chk({p, "_pulse_cycle"}, pulse_cyc, v.drain + 1);
            chk({p, "_redirect_cycles"}, rv_n, v.rdly + 1);
        end
        chk({p, "_sb_empty"}, sb.size(), 0);
        mem_busy = 1'b0;
        redirect_ready = 1'b0;
    endtask

    task automatic base(input int i);
        vecs[i] = '{default: 0};
        vecs[i].priv  = 2'd3;
        vecs[i].mtvec = 32'h8000_0000;
    endtask

    initial begin
        // Table of events, all applied from IDLE.
        base(0);  vecs[0].ev = 1; vecs[0].code = 4'd2; vecs[0].epc = 32'h100;
                  vecs[0].tval = 32'hDEAD; vecs[0].kind = 1; vecs[0].cause = 32'd2;
                  vecs[0].pc = 32'h100; vecs[0].val = 32'hDEAD;
                  vecs[0].target = 32'h8000_0000; vecs[0].drain = 1;
        base(1);  vecs[1].tp = 1; vecs[1].mtie = 1; vecs[1].smie = 0; vecs[1].cv = 1;
                  vecs[1].cpc = 32'h300;
        base(2);  vecs[2].tp = 1; vecs[2].mtie = 1; vecs[2].smie = 0; vecs[2].priv = 2'd0;
                  vecs[2].cv = 1; vecs[2].cpc = 32'h340; vecs[2].mtvec = 32'h8000_0100;
                  vecs[2].kind = 1; vecs[2].cause = 32'h8000_0007; vecs[2].pc = 32'h340;
                  vecs[2].target = 32'h8000_0100; vecs[2].drain = 1;
        base(3);  vecs[3].mret = 1; vecs[3].mepc = 32'h204; vecs[3].rdly = 3;
                  vecs[3].kind = 2; vecs[3].target = 32'h204; vecs[3].drain = 1;
        base(4);  vecs[4].ev = 1; vecs[4].code = 4'd5; vecs[4].epc = 32'h2000;
                  vecs[4].tval = 32'h2004; vecs[4].busy = 5; vecs[4].kind = 1;
                  vecs[4].cause = 32'd5; vecs[4].pc = 32'h2000; vecs[4].val = 32'h2004;
                  vecs[4].target = 32'h8000_0000; vecs[4].drain = 5;
        base(5);  vecs[5].ev = 1; vecs[5].code = 4'd7; vecs[5].epc = 32'h500;
                  vecs[5].tval = 32'h11; vecs[5].mret = 1; vecs[5].mepc = 32'h9999;
                  vecs[5].tp = 1; vecs[5].mtie = 1; vecs[5].smie = 1; vecs[5].cv = 1;
                  vecs[5].cpc = 32'h504; vecs[5].kind = 1; vecs[5].cause = 32'd7;
                  vecs[5].pc = 32'h500; vecs[5].val = 32'h11;
                  vecs[5].target = 32'h8000_0000; vecs[5].drain = 1;
        base(6);  vecs[6].mret = 1; vecs[6].mepc = 32'h3000; vecs[6].tp = 1;
                  vecs[6].mtie = 1; vecs[6].smie = 1; vecs[6].cv = 1; vecs[6].cpc = 32'h600;
                  vecs[6].kind = 2; vecs[6].target = 32'h3000; vecs[6].drain = 1;
        base(7);  vecs[7].tp = 1; vecs[7].mtie = 0; vecs[7].smie = 1; vecs[7].cv = 1;
        base(8);  vecs[8].tp = 1; vecs[8].mtie = 1; vecs[8].smie = 1; vecs[8].cv = 1;
                  vecs[8].cpc = 32'h420; vecs[8].mtvec = 32'h8000_0001; vecs[8].kind = 1;
                  vecs[8].cause = 32'h8000_0007; vecs[8].pc = 32'h420; vecs[8].drain = 1;
`ifdef TRAP_VECTORED_EN
                  vecs[8].target = 32'h8000_001C;
`else
                  vecs[8].target = 32'h8000_0000;
`endif
        base(9);  vecs[9].ev = 1; vecs[9].code = 4'd8; vecs[9].epc = 32'h440;
                  vecs[9].mtvec = 32'h8000_0001; vecs[9].kind = 1; vecs[9].cause = 32'd8;
                  vecs[9].pc = 32'h440; vecs[9].target = 32'h8000_0000; vecs[9].drain = 1;
        base(10); vecs[10].tp = 1; vecs[10].mtie = 1; vecs[10].smie = 1; vecs[10].cv = 0;
        base(11); vecs[11].mret = 1; vecs[11].mepc = 32'h1000_0000; vecs[11].busy = 3;
                  vecs[11].kind = 2; vecs[11].target = 32'h1000_0000; vecs[11].drain = 3;
        base(12); vecs[12].ev = 1; vecs[12].code = 4'd4; vecs[12].epc = 32'h600;
                  vecs[12].tval = 32'h604; vecs[12].busy = 1000; vecs[12].kind = 1;
                  vecs[12].cause = 32'd4; vecs[12].pc = 32'h600; vecs[12].val = 32'h604;
                  vecs[12].target = 32'h8000_0000; vecs[12].drain = DrainTo;

        rst = 1'b1;
        clear_events();
        exc_code = 4'd0; exc_pc = 32'h0; exc_tval = 32'h0; commit_pc = 32'h0;
        mie_mtie = 1'b0; mstatus_mie = 1'b0; priv_mode = 2'd3;
        mtvec_in = 32'h0; mepc_in = 32'h0; mem_busy = 1'b0; redirect_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_redirect_valid", redirect_valid, 0);
        chk("reset_drain_timeout", drain_timeout, 0);
        chk("reset_cause", trap_cause, 0);

        for (int i = 0; i < 13; i++) begin
            if (i == 12) chk("drain_timeout_before", drain_timeout, 0);
            run_vec(vecs[i], i);
        end
        chk("drain_timeout_after", drain_timeout, 1);

        // Reset asserted mid-drain: outputs drop at once and no pulse follows.
        exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 32'h700; mem_busy = 1'b1;
        tick();
        clear_events();
        tick();
        chk("rst_pre_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_drain_timeout", drain_timeout, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_post_pulse", {30'b0, trap_enter, mret_exec}, 0);
            chk("rst_post_stall", stall, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
